// File: rtl/lsu_bus_master.sv
// Load/store bus master: turns MEM-stage load/store controls into one word-wide req/ack bus transaction.
// Define LSU_WRITE_LOG_EN to print a simulation log line for every acknowledged write.
module lsu_bus_master #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [1:0]  StoreType,
  input  logic [1:0]  LoadType,
  input  logic        SignRead,
  input  logic [31:0] WPC,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        Busy,
  output logic        AddrExc,
  output logic        BusErr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [1:0]  o_dbg_state
);

  // Bus handshake: bus_req rises with address/be/wdata already stable and holds them
  // unchanged until the first rising edge where bus_ack=1 (bus_rdata valid on that edge);
  // bus_req then drops for at least one cycle. bus_ack seen while bus_req=0 is ignored.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic        r_we;
  logic        r_half;
  logic        r_byte;
  logic [1:0]  r_off;
  logic        r_sign;
  logic [31:0] r_wpc;

  logic        w_req;
  logic [1:0]  w_size;
  logic        w_half;
  logic        w_byte;
  logic        w_mis;
  logic        w_start;
  logic [15:0] w_cnt_nxt;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shift;
  logic [31:0] w_load;

  assign w_req     = MemWrite | MemRead;
  assign w_size    = MemWrite ? StoreType : LoadType;
  assign w_half    = (w_size == 2'd1);
  assign w_byte    = (w_size == 2'd2);
  assign w_mis     = w_half ? Addr[0] : (w_byte ? 1'b0 : (Addr[1:0] != 2'b00));
  assign w_start   = (r_state == S_IDLE) & w_req & ~w_mis;
  assign w_cnt_nxt = r_cnt + 16'd1;

  assign AddrExc     = (r_state == S_IDLE) & w_req & w_mis;
  // Gated by reset so the pipeline is released the moment reset asserts.
  assign Busy        = Reset & (w_start | (r_state == S_REQ));
  assign o_dbg_state = r_state;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = WD;
    if (MemWrite) begin
      if (w_half) begin
        w_be    = Addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {WD[15:0], WD[15:0]};
      end else if (w_byte) begin
        w_be    = 4'b0001 << Addr[1:0];
        w_wdata = {4{WD[7:0]}};
      end
    end
  end

  always_comb begin
    w_shift = bus_rdata >> {r_off, 3'b000};
    w_load  = bus_rdata;
    if (r_half)
      w_load = {{16{r_sign & w_shift[15]}}, w_shift[15:0]};
    else if (r_byte)
      w_load = {{24{r_sign & w_shift[7]}}, w_shift[7:0]};
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_half    <= 1'b0;
      r_byte    <= 1'b0;
      r_off     <= 2'b00;
      r_sign    <= 1'b0;
      r_wpc     <= '0;
      RD        <= '0;
      BusErr    <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
    end else begin
      BusErr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_we      <= MemWrite;
            r_half    <= w_half;
            r_byte    <= w_byte;
            r_off     <= Addr[1:0];
            r_sign    <= SignRead;
            r_wpc     <= WPC;
            r_cnt     <= '0;
            bus_req   <= 1'b1;
            bus_we    <= MemWrite;
            bus_addr  <= {Addr[31:2], 2'b00};
            bus_be    <= w_be;
            bus_wdata <= w_wdata;
            r_state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!r_we) RD <= w_load;
            r_state <= S_DONE;
          end else if (w_cnt_nxt == TIMEOUT_LIM) begin
            bus_req <= 1'b0;
            BusErr  <= 1'b1;
            if (!r_we) RD <= '0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        S_DONE: begin
          // The MEM stage still shows the finished request this cycle; do not restart it.
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef LSU_WRITE_LOG_EN
  always @(posedge Clock) begin
    if (Reset && r_state == S_REQ && bus_ack && r_we)
      $display("@%h: *%h <= %h (be %b)", r_wpc, bus_addr, bus_wdata, bus_be);
  end
`else
  logic w_unused_wpc;
  assign w_unused_wpc = ^r_wpc;
`endif

endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed bench for lsu_bus_master: vector table of single transactions plus reset and timeout sequences.
module tb_lsu_bus_master;

  localparam logic [31:0] RWORD = 32'heebb56dd;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        MemWrite, MemRead, SignRead, bus_ack;
  logic [1:0]  StoreType, LoadType;
  logic [31:0] WPC, Addr, WD, bus_rdata;
  logic [31:0] RD, bus_addr, bus_wdata;
  logic        Busy, AddrExc, BusErr, bus_req, bus_we;
  logic [3:0]  bus_be;
  logic [1:0]  o_dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  lsu_bus_master #(.TIMEOUT_CYCLES(4)) dut (
    .Clock(Clock), .Reset(Reset), .MemWrite(MemWrite), .MemRead(MemRead),
    .StoreType(StoreType), .LoadType(LoadType), .SignRead(SignRead), .WPC(WPC),
    .Addr(Addr), .WD(WD), .RD(RD), .Busy(Busy), .AddrExc(AddrExc), .BusErr(BusErr),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .o_dbg_state(o_dbg_state)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic        mw;
    logic        mr;
    logic [1:0]  st;
    logic [1:0]  lt;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wd;
    int          dly;
    logic        exc;
    logic        we;
    logic [31:0] baddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic clear_inputs();
    MemWrite = 1'b0; MemRead = 1'b0; StoreType = 2'd0; LoadType = 2'd0;
    SignRead = 1'b0; Addr = '0; WD = '0;
  endtask

  task automatic run_txn(input vec_t v);
    int busy_cnt;
    busy_cnt  = 0;
    MemWrite  = v.mw;  MemRead  = v.mr;
    StoreType = v.st;  LoadType = v.lt;
    SignRead  = v.sgn; Addr     = v.addr; WD = v.wd;
    WPC       = $urandom;
    #1;
    chk("addr_exc", {31'd0, AddrExc}, {31'd0, v.exc});
    if (v.exc) begin
      chk("busy_on_exc", {31'd0, Busy}, 32'd0);
      step();
      chk("req_on_exc", {31'd0, bus_req}, 32'd0);
      clear_inputs();
      step();
    end else begin
      if (Busy) busy_cnt++;
      step();
      chk("bus_req", {31'd0, bus_req}, 32'd1);
      chk("bus_we", {31'd0, bus_we}, {31'd0, v.we});
      chk("bus_addr", bus_addr, v.baddr);
      chk("bus_be", {28'd0, bus_be}, {28'd0, v.be});
      if (v.we) chk("bus_wdata", bus_wdata, v.wdata);
      for (int d = 0; d < v.dly; d++) begin
        if (Busy) busy_cnt++;
        step();
      end
      bus_ack   = 1'b1;
      bus_rdata = RWORD;
      if (Busy) busy_cnt++;
      step();
      bus_ack   = 1'b0;
      bus_rdata = $urandom;
      chk("done_busy", {31'd0, Busy}, 32'd0);
      chk("done_req", {31'd0, bus_req}, 32'd0);
      chk("done_buserr", {31'd0, BusErr}, 32'd0);
      chk("rd", RD, v.rd);
      chk("busy_cycles", busy_cnt, 2 + v.dly);
      clear_inputs();
      step();
      chk("back_idle", {30'd0, o_dbg_state}, 32'd0);
    end
  endtask

  initial begin
    //         mw    mr    st    lt    sgn   addr           wd             dly exc   we    baddr          be       wdata          rd
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 32'h0000_0000, 32'h1234_5678, 1, 1'b0, 1'b1, 32'h0000_0000, 4'b1111, 32'h1234_5678, 32'h0000_0000};
    vecs[1]  = '{1'b1, 1'b0, 2'd1, 2'd0, 1'b0, 32'h0000_0002, 32'h0000_aabb, 0, 1'b0, 1'b1, 32'h0000_0000, 4'b1100, 32'haabb_aabb, 32'h0000_0000};
    vecs[2]  = '{1'b1, 1'b0, 2'd2, 2'd0, 1'b0, 32'h0000_0003, 32'haabb_ccee, 0, 1'b0, 1'b1, 32'h0000_0000, 4'b1000, 32'heeee_eeee, 32'h0000_0000};
    vecs[3]  = '{1'b0, 1'b1, 2'd0, 2'd2, 1'b1, 32'h0000_0000, 32'h0000_0000, 0, 1'b0, 1'b0, 32'h0000_0000, 4'b1111, 32'h0,          32'hffff_ffdd};
    vecs[4]  = '{1'b0, 1'b1, 2'd0, 2'd2, 1'b0, 32'h0000_0000, 32'h0000_0000, 1, 1'b0, 1'b0, 32'h0000_0000, 4'b1111, 32'h0,          32'h0000_00dd};
    vecs[5]  = '{1'b0, 1'b1, 2'd0, 2'd1, 1'b1, 32'h0000_0000, 32'h0000_0000, 0, 1'b0, 1'b0, 32'h0000_0000, 4'b1111, 32'h0,          32'h0000_56dd};
    vecs[6]  = '{1'b0, 1'b1, 2'd0, 2'd1, 1'b1, 32'h0000_0002, 32'h0000_0000, 2, 1'b0, 1'b0, 32'h0000_0000, 4'b1111, 32'h0,          32'hffff_eebb};
    vecs[7]  = '{1'b1, 1'b1, 2'd0, 2'd1, 1'b0, 32'h0000_0000, 32'h1234_5678, 0, 1'b0, 1'b1, 32'h0000_0000, 4'b1111, 32'h1234_5678, 32'hffff_eebb};
    vecs[8]  = '{1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 32'h0000_0002, 32'h0000_0000, 0, 1'b1, 1'b0, 32'h0,          4'b0000, 32'h0,          32'hffff_eebb};
    vecs[9]  = '{1'b0, 1'b1, 2'd0, 2'd2, 1'b0, 32'h0000_0107, 32'h0000_0000, 2, 1'b0, 1'b0, 32'h0000_0104, 4'b1111, 32'h0,          32'h0000_00ee};
    vecs[10] = '{1'b1, 1'b0, 2'd1, 2'd0, 1'b0, 32'h0000_000a, 32'h1234_beef, 0, 1'b0, 1'b1, 32'h0000_0008, 4'b1100, 32'hbeef_beef, 32'h0000_00ee};
    vecs[11] = '{1'b1, 1'b0, 2'd1, 2'd0, 1'b0, 32'h0000_0001, 32'h0000_1111, 0, 1'b1, 1'b1, 32'h0,          4'b0000, 32'h0,          32'h0000_00ee};
    vecs[12] = '{1'b0, 1'b1, 2'd0, 2'd3, 1'b1, 32'h0000_0020, 32'h0000_0000, 1, 1'b0, 1'b0, 32'h0000_0020, 4'b1111, 32'h0,          32'heebb_56dd};
    vecs[13] = '{1'b1, 1'b0, 2'd2, 2'd0, 1'b0, 32'h0000_0005, 32'h0000_0077, 0, 1'b0, 1'b1, 32'h0000_0004, 4'b0010, 32'h7777_7777, 32'heebb_56dd};
    vecs[14] = '{1'b0, 1'b1, 2'd0, 2'd1, 1'b0, 32'h0000_0002, 32'h0000_0000, 0, 1'b0, 1'b0, 32'h0000_0000, 4'b1111, 32'h0,          32'h0000_eebb};

    // clock/reset
    Reset = 1'b0; bus_ack = 1'b0; bus_rdata = '0; WPC = '0;
    clear_inputs();
    step(); step();
    chk("rst_rd", RD, 32'd0);
    chk("rst_req", {31'd0, bus_req}, 32'd0);
    chk("rst_buserr", {31'd0, BusErr}, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_state", {30'd0, o_dbg_state}, 32'd0);
    Reset = 1'b1;
    step();

    for (int i = 0; i < 15; i++) run_txn(vecs[i]);

    // Reset in the middle of a load
    MemRead = 1'b1; LoadType = 2'd0; Addr = 32'h0000_0080;
    #1;
    step();
    chk("mid_req", {31'd0, bus_req}, 32'd1);
    #2;
    Reset = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, bus_req}, 32'd0);
    chk("mid_rst_busy", {31'd0, Busy}, 32'd0);
    chk("mid_rst_rd", RD, 32'd0);
    chk("mid_rst_state", {30'd0, o_dbg_state}, 32'd0);
    clear_inputs();
    step();
    Reset = 1'b1;
    step();
    run_txn('{1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 32'h0000_0080, 32'h0, 0, 1'b0, 1'b0,
              32'h0000_0080, 4'b1111, 32'h0, RWORD});

    // Timeout: responder never acks
    MemRead = 1'b1; LoadType = 2'd0; Addr = 32'h0000_0040;
    #1;
    chk("to_busy_start", {31'd0, Busy}, 32'd1);
    step();
    for (int k = 0; k < 4; k++) begin
      chk("to_req_high", {31'd0, bus_req}, 32'd1);
      chk("to_no_err", {31'd0, BusErr}, 32'd0);
      step();
    end
    chk("to_buserr", {31'd0, BusErr}, 32'd1);
    chk("to_rd_zero", RD, 32'd0);
    chk("to_req_low", {31'd0, bus_req}, 32'd0);
    chk("to_busy_low", {31'd0, Busy}, 32'd0);
    chk("to_state_done", {30'd0, o_dbg_state}, 32'd2);
    bus_ack = 1'b1; bus_rdata = 32'hffff_ffff;
    clear_inputs();
    step();
    chk("to_err_pulse", {31'd0, BusErr}, 32'd0);
    chk("to_state_idle", {30'd0, o_dbg_state}, 32'd0);
    chk("stray_ack_rd", RD, 32'd0);
    step();
    chk("stray_ack_rd2", RD, 32'd0);
    chk("stray_ack_req", {31'd0, bus_req}, 32'd0);
    bus_ack = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
